// File: rtl/reset_request_ctrl.sv
// Reset-request controller: button / software / watchdog requests become one fixed-length
// active-low pulse plus cooldown. Define RSTREQ_DEBOUNCE_EN to add the button debounce filter.
module reset_request_ctrl #(
    parameter int PULSE_LEN = 16,
    parameter int COOLDOWN  = 8,
    parameter int DEBOUNCE  = 4,
    parameter int CNTW      = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            BTN_N,
    input  logic            SW_REQ,
    output logic            SW_ACK,
    input  logic            WDT_EXPIRE,
    output logic            OUT_RST_N,
    output logic            BUSY,
    output logic [2:0]      CAUSE,
    output logic [CNTW-1:0] RST_COUNT
);

    localparam int CMAX = (PULSE_LEN > COOLDOWN) ? PULSE_LEN : COOLDOWN;
    localparam int CW   = $clog2(CMAX + 1);

    if (PULSE_LEN < 1 || DEBOUNCE < 1) begin : g_param_check
        $error("reset_request_ctrl: PULSE_LEN and DEBOUNCE must be >= 1");
    end

    typedef enum logic [1:0] {ASSERT, COOL, IDLE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            out_n, ack_n;
    logic [2:0]      cause_n, src;
    logic [CNTW-1:0] count_n;

    // Button path: 2-flop synchronizer, optional filter, then falling-edge detect.
    logic btn_s1, btn_s2, btn_lvl, btn_prev, btn_req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_s1   <= 1'b1;
            btn_s2   <= 1'b1;
            btn_prev <= 1'b1;
        end else begin
            btn_s1   <= BTN_N;
            btn_s2   <= btn_s1;
            btn_prev <= btn_lvl;
        end
    end

`ifdef RSTREQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic          btn_filt;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_filt <= 1'b1;
            db_cnt   <= '0;
        end else if (btn_s2 != btn_filt) begin
            if (db_cnt == DW'(DEBOUNCE - 1)) begin
                btn_filt <= btn_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign btn_lvl = btn_filt;
`else
    assign btn_lvl = btn_s2;
`endif

    assign btn_req = btn_prev & ~btn_lvl;
    assign src     = {WDT_EXPIRE, SW_REQ, btn_req};
    assign BUSY    = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = 1'b1;
        ack_n   = 1'b0;
        cause_n = CAUSE;
        count_n = RST_COUNT;
        case (state)
            ASSERT: begin
                out_n   = 1'b0;
                cause_n = CAUSE | src;
                if (cnt == CW'(1)) begin
                    out_n = 1'b1;
                    if (COOLDOWN == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = COOL;
                        cnt_n   = CW'(COOLDOWN);
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            COOL: begin
                if (cnt == CW'(1)) state_n = IDLE;
                else               cnt_n   = cnt - 1'b1;
            end
            IDLE: begin
                if (|src) begin
                    state_n = ASSERT;
                    cnt_n   = CW'(PULSE_LEN);
                    out_n   = 1'b0;
                    ack_n   = SW_REQ;
                    cause_n = src;
                    if (RST_COUNT != '1) count_n = RST_COUNT + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ASSERT;
            cnt       <= CW'(PULSE_LEN);
            OUT_RST_N <= 1'b0;
            SW_ACK    <= 1'b0;
            CAUSE     <= '0;
            RST_COUNT <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            OUT_RST_N <= out_n;
            SW_ACK    <= ack_n;
            CAUSE     <= cause_n;
            RST_COUNT <= count_n;
        end
    end

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Scoreboard bench for reset_request_ctrl: expected pulses are queued by the stimulus and
// checked by a monitor that measures every low pulse of OUT_RST_N and the following cooldown.
module tb_reset_request_ctrl;

    localparam int PL = 16;
    localparam int CD = 8;
    localparam int DB = 4;
    localparam int CW = 2;
`ifdef RSTREQ_DEBOUNCE_EN
    localparam int BTN_LAT     = 3 + DB;
    localparam bit GLITCH_HITS = 1'b0;
`else
    localparam int BTN_LAT     = 3;
    localparam bit GLITCH_HITS = 1'b1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BTN_N = 1'b1;
    logic          SW_REQ = 1'b0;
    logic          WDT_EXPIRE = 1'b0;
    logic          SW_ACK, OUT_RST_N, BUSY;
    logic [2:0]    CAUSE;
    logic [CW-1:0] RST_COUNT;

    reset_request_ctrl #(.PULSE_LEN(PL), .COOLDOWN(CD), .DEBOUNCE(DB), .CNTW(CW)) dut (
        .CLK(CLK), .RST(RST), .BTN_N(BTN_N), .SW_REQ(SW_REQ), .SW_ACK(SW_ACK),
        .WDT_EXPIRE(WDT_EXPIRE), .OUT_RST_N(OUT_RST_N), .BUSY(BUSY),
        .CAUSE(CAUSE), .RST_COUNT(RST_COUNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int            len;
        logic [2:0]    cause;
        logic [CW-1:0] cnt;
        int            acks;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input int len, input logic [2:0] c, input logic [CW-1:0] n,
                                 input int a);
        exp_t e;
        e.len = len; e.cause = c; e.cnt = n; e.acks = a;
        sb.push_back(e);
    endfunction

    // Monitor: measures each low pulse, then the BUSY tail that follows it.
    int   m_len = 0, m_acks = 0, m_cool = 0;
    bit   m_cool_act = 1'b0;
    logic m_prev = 1'b0;
    exp_t m_exp;

    always @(negedge CLK) begin
        if (RST) begin
            m_len = 0; m_acks = 0; m_cool_act = 1'b0; m_prev = 1'b0;
        end else begin
            if (SW_ACK === 1'b1) m_acks++;
            if (m_cool_act) begin
                if (BUSY === 1'b1) m_cool++;
                else begin
                    chk("cooldown_len", m_cool, CD);
                    m_cool_act = 1'b0;
                end
            end
            if (OUT_RST_N === 1'b0) begin
                m_len = (m_prev === 1'b1) ? 1 : m_len + 1;
            end else if (m_prev === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_pulse: got pulse len %0d cause %b, expected none",
                             m_len, CAUSE);
                end else begin
                    m_exp = sb.pop_front();
                    chk("pulse_len", m_len, m_exp.len);
                    chk("cause", CAUSE, m_exp.cause);
                    chk("rst_count", RST_COUNT, m_exp.cnt);
                    chk("sw_ack_count", m_acks, m_exp.acks);
                end
                m_acks = 0; m_cool_act = 1'b1; m_cool = (BUSY === 1'b1) ? 1 : 0;
            end
            m_prev = OUT_RST_N;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && BUSY !== 1'b0; i++) tick(1);
        if (BUSY !== 1'b0) begin
            checks++; fails++;
            $display("FAIL wait_idle: BUSY %b, expected 0 within 200 cycles", BUSY);
        end
    endtask

    task automatic wait_out_low();
        for (int i = 0; i < 60 && OUT_RST_N !== 1'b0; i++) tick(1);
        if (OUT_RST_N !== 1'b0) begin
            checks++; fails++;
            $display("FAIL wait_out_low: OUT_RST_N %b, expected 0 within 60 cycles", OUT_RST_N);
        end
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 10 && SW_ACK !== 1'b1; i++) tick(1);
        if (SW_ACK !== 1'b1) begin
            checks++; fails++;
            $display("FAIL wait_ack: SW_ACK %b, expected 1 within 10 cycles", SW_ACK);
        end
    endtask

    initial begin
        int n;
        // Power-on
        RST = 1'b1;
        tick(5);
        chk("rst_out_rst_n", OUT_RST_N, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_sw_ack", SW_ACK, 0);
        chk("rst_cause", CAUSE, 0);
        chk("rst_count0", RST_COUNT, 0);
        push(PL, 3'b000, 0, 0);
        RST = 1'b0;
        wait_idle(); tick(3);

        // Software handshake, dropped on ack
        push(PL, 3'b010, 1, 1);
        SW_REQ = 1'b1; wait_ack(); SW_REQ = 1'b0;
        wait_idle(); tick(5);

        // Software and watchdog together
        push(PL, 3'b110, 2, 1);
        SW_REQ = 1'b1; WDT_EXPIRE = 1'b1; tick(1); WDT_EXPIRE = 1'b0;
        wait_ack(); SW_REQ = 1'b0;
        wait_idle(); tick(5);

        // Watchdog during ASSERT joins CAUSE; button pressed in COOL is dropped
        push(PL, 3'b110, 3, 1);
        SW_REQ = 1'b1; wait_ack(); SW_REQ = 1'b0;
        tick(4); WDT_EXPIRE = 1'b1; tick(1); WDT_EXPIRE = 1'b0;
        tick(11); BTN_N = 1'b0; tick(40); BTN_N = 1'b1;
        tick(12); wait_idle(); tick(5);

        // Two-cycle glitch: request only without the filter; count already saturated
        if (GLITCH_HITS) push(PL, 3'b001, 3, 0);
        BTN_N = 1'b0; tick(2); BTN_N = 1'b1;
        tick(10); wait_idle(); tick(5);

        // Held press: latency, then a single pulse over 100 cycles
        push(PL, 3'b001, 3, 0);
        BTN_N = 1'b0; n = 0;
        while (n < 20 && OUT_RST_N !== 1'b0) begin tick(1); n++; end
        chk("btn_latency", n, BTN_LAT);
        tick(100); BTN_N = 1'b1;
        tick(10); wait_idle(); tick(5);

        // Watchdog level held through COOL is accepted again
        push(PL, 3'b100, 3, 0);
        push(PL, 3'b100, 3, 0);
        WDT_EXPIRE = 1'b1;
        wait_out_low(); wait_idle(); wait_out_low();
        WDT_EXPIRE = 1'b0;
        wait_idle(); tick(5);

        // Reset in the middle of a pulse
        WDT_EXPIRE = 1'b1; tick(1); WDT_EXPIRE = 1'b0;
        tick(6); RST = 1'b1; tick(1);
        chk("midrst_cause", CAUSE, 0);
        chk("midrst_count", RST_COUNT, 0);
        chk("midrst_out_rst_n", OUT_RST_N, 0);
        chk("midrst_busy", BUSY, 1);
        chk("midrst_sw_ack", SW_ACK, 0);
        push(PL, 3'b000, 0, 0);
        tick(1); RST = 1'b0;
        wait_idle(); tick(5);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
